// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that locks the grant for a whole last-delimited burst and
// feeds one registered valid/ready slave channel. Latency: 1 cycle upstream accept to valid_down.
// Backpressure: ready_down stalls the output slice; only the current winner sees ready_up.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   data_up/valid_up/last_up  packed per-requester payload, valid and end-of-burst flag
//   ready_up               one-hot (or zero) ready back to the winning requester
//   data_down/valid_down/last_down/grant_id  registered output beat and its source index
//   ready_down             slave ready
module rr_burst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ*DATA_W-1:0] data_up,
  input  logic [NUM_REQ-1:0]        valid_up,
  input  logic [NUM_REQ-1:0]        last_up,
  output logic [NUM_REQ-1:0]        ready_up,
  output logic [DATA_W-1:0]         data_down,
  output logic                      valid_down,
  output logic                      last_down,
  output logic [ID_W-1:0]           grant_id,
  input  logic                      ready_down
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] owner_q, owner_d;

  logic              accept_en;
  logic              win_vld;
  logic [ID_W-1:0]   win_idx;
  logic              win_last;
  logic [DATA_W-1:0] win_data;
  logic              transfer;
  int                scan_idx;

  // The output slice can take a new beat when empty or when it drains this cycle.
  assign accept_en = ~valid_down | ready_down;

  // Winner: the burst owner while locked (even if it is momentarily idle), otherwise
  // the first valid requester after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    if (state_q == LOCK) begin
      win_vld = valid_up[owner_q];
      win_idx = owner_q;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!win_vld && valid_up[scan_idx]) begin
          win_vld = 1'b1;
          win_idx = ID_W'(scan_idx);
        end
      end
    end
  end

  assign transfer = win_vld & accept_en;
  assign win_last = last_up[win_idx];
  assign win_data = data_up[int'(win_idx)*DATA_W +: DATA_W];

  always_comb begin
    ready_up = '0;
    if (transfer) ready_up[win_idx] = 1'b1;
  end

  // Burst lock: a non-last beat taken from IDLE pins the grant until the owner's last beat.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (transfer) begin
      case (state_q)
        IDLE: begin
          if (!win_last) begin
            state_d = LOCK;
            owner_d = win_idx;
          end
        end
        LOCK: begin
          if (win_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      valid_down <= 1'b0;
      data_down  <= '0;
      last_down  <= 1'b0;
      grant_id   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (transfer) begin
        data_down  <= win_data;
        last_down  <= win_last;
        grant_id   <= win_idx;
        valid_down <= 1'b1;
        rr_ptr_q   <= win_idx;
      end else if (ready_down) begin
        valid_down <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed scenarios plus random traffic, all checked
// against a behavioural model of the arbitration rules kept in this file.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_rr_burst_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;
  localparam int VW = N + 2 + IW + W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] data_up;
  logic [N-1:0]   valid_up, last_up, ready_up;
  logic [W-1:0]   data_down;
  logic           valid_down, last_down, ready_down;
  logic [IW-1:0]  grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  rr_burst_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .data_up(data_up), .valid_up(valid_up),
    .last_up(last_up), .ready_up(ready_up), .data_down(data_down),
    .valid_down(valid_down), .last_down(last_down), .grant_id(grant_id),
    .ready_down(ready_down)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit           m_locked;
  int           m_owner, m_ptr, m_id;
  bit           m_vld, m_last;
  logic [W-1:0] m_data;

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = N - 1;
    m_vld = 0; m_last = 0; m_data = '0; m_id = 0;
  endtask

  function automatic int m_winner();
    if (m_locked) return valid_up[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (valid_up[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = m_winner();
    if (w >= 0 && (!m_vld || ready_down)) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [VW-1:0] m_vec();
    return {m_ready(), m_vld, m_last, IW'(m_id), m_data};
  endfunction

  // Advance one clock edge, updating the model with what the edge should do.
  task automatic tick();
    logic [N-1:0] r;
    int           w;
    logic [W-1:0] d;
    logic         l, rd;
    w = m_winner(); r = m_ready(); rd = ready_down;
    d = '0; l = 1'b0;
    if (w >= 0) begin
      d = data_up[w*W +: W];
      l = last_up[w];
    end
    @(posedge clk);
    if (r != '0) begin
      m_data = d; m_last = l; m_id = w; m_vld = 1; m_ptr = w;
      if (!m_locked && !l) begin
        m_locked = 1; m_owner = w;
      end else if (m_locked && l) begin
        m_locked = 0;
      end
    end else if (rd) begin
      m_vld = 0;
    end
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    data_up[i*W +: W] = v;
  endtask

  task automatic drain();
    valid_up = '0; last_up = '0; ready_down = 1'b1;
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; valid_up = '0; last_up = '0; ready_down = 1'b0; data_up = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ready_up, valid_down, last_down, grant_id, data_down} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", {ready_up, valid_down, last_down, grant_id, data_down});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rr_sequence();
    ready_down = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 32'h1000_0000 + i);
    for (int c = 0; c <= 5; c++) begin
      valid_up = (c < 5) ? 4'b1111 : 4'b0000;
      last_up  = 4'b1111;
      #1;
      n_tests++;
      if ({ready_up, valid_down, last_down, grant_id, data_down} !== m_vec()) begin
        n_fail++;
        $display("FAIL rr_model c=%0d: got %h want %h", c,
                 {ready_up, valid_down, last_down, grant_id, data_down}, m_vec());
      end
      n_tests++;
      if (c == 0) begin
        if (valid_down !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_first_valid: got %b want 0", valid_down);
        end
      end else if ({valid_down, grant_id, data_down} !==
                   {1'b1, IW'((c - 1) % N), 32'h1000_0000 + 32'((c - 1) % N)}) begin
        n_fail++;
        $display("FAIL rr_grant c=%0d: got v=%b id=%0d d=%h want id=%0d", c,
                 valid_down, grant_id, data_down, (c - 1) % N);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_burst_lock();
    logic [5:0]     v1, l1;
    logic [N-1:0]   er [6];
    logic [IW:0]    eg [6];
    v1 = 6'b001011;  // cycle c is bit c: 1,1,0,1,0,0
    l1 = 6'b001000;
    er = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b0100};
    eg = '{3'b000, 3'b101, 3'b101, 3'b001, 3'b101, 3'b110};
    ready_down = 1'b1;
    for (int c = 0; c < 6; c++) begin
      valid_up = {1'b0, 1'b1, v1[c], 1'b0};
      last_up  = {1'b0, 1'b1, l1[c], 1'b0};
      set_data(1, 32'hB100_0000 + c);
      set_data(2, 32'hB200_0000 + c);
      #1;
      n_tests++;
      if ({ready_up, valid_down, last_down, grant_id, data_down} !== m_vec()) begin
        n_fail++;
        $display("FAIL burst_model c=%0d: got %h want %h", c,
                 {ready_up, valid_down, last_down, grant_id, data_down}, m_vec());
      end
      n_tests++;
      if (ready_up !== er[c] || {valid_down, grant_id} !== eg[c]) begin
        n_fail++;
        $display("FAIL burst_lock c=%0d: got rdy=%b v/id=%b want rdy=%b v/id=%b", c,
                 ready_up, {valid_down, grant_id}, er[c], eg[c]);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_backpressure();
    for (int c = 0; c <= 6; c++) begin
      valid_up   = (c < 5) ? 4'b1000 : 4'b0000;
      last_up    = 4'b1000;
      ready_down = (c >= 5);
      set_data(3, (c == 0) ? 32'hA5A5_0003 : 32'hDEAD_0000 + c);
      #1;
      n_tests++;
      if ({ready_up, valid_down, last_down, grant_id, data_down} !== m_vec()) begin
        n_fail++;
        $display("FAIL bp_model c=%0d: got %h want %h", c,
                 {ready_up, valid_down, last_down, grant_id, data_down}, m_vec());
      end
      n_tests++;
      if (c == 0 && (ready_up !== 4'b1000 || valid_down !== 1'b0)) begin
        n_fail++;
        $display("FAIL bp_accept: got rdy=%b v=%b want rdy=1000 v=0", ready_up, valid_down);
      end else if (c >= 1 && c <= 5 &&
                   {ready_up, valid_down, grant_id, data_down} !== {4'b0000, 1'b1, 2'd3, 32'hA5A5_0003}) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d: got rdy=%b v=%b id=%0d d=%h want 0000 1 3 a5a50003", c,
                 ready_up, valid_down, grant_id, data_down);
      end else if (c == 6 && (valid_down !== 1'b0 || data_down !== 32'hA5A5_0003)) begin
        n_fail++;
        $display("FAIL bp_release: got v=%b d=%h want v=0 d=a5a50003", valid_down, data_down);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [N-1:0] er [2];
    er = '{4'b0001, 4'b1000};
    ready_down = 1'b1;
    for (int c = 0; c < 2; c++) begin
      valid_up = 4'b1001; last_up = 4'b1001;
      set_data(0, 32'hE000_0000 + c); set_data(3, 32'hE300_0000 + c);
      #1;
      n_tests++;
      if (ready_up !== er[c] || {ready_up, valid_down, last_down, grant_id, data_down} !== m_vec()) begin
        n_fail++;
        $display("FAIL wrap c=%0d: got rdy=%b want %b (model %h)", c, ready_up, er[c], m_vec());
      end
      tick();
    end
    drain();
  endtask

  task automatic test_stall_stream();
    logic [3:0]   rpat;
    logic [W-1:0] sent [$];
    int           beat, rcvd;
    rpat = 4'b1101;  // cycle c is bit c: 1,0,1,1 then 1
    beat = 0; rcvd = 0;
    for (int c = 0; c < 20; c++) begin
      valid_up   = (beat < 5) ? 4'b0001 : 4'b0000;
      last_up    = (beat == 4) ? 4'b0001 : 4'b0000;
      set_data(0, 32'hC000_0000 + beat);
      ready_down = (c < 4) ? rpat[c] : 1'b1;
      #1;
      n_tests++;
      if ({ready_up, valid_down, last_down, grant_id, data_down} !== m_vec() ||
          ready_up[0] !== (valid_up[0] & (~valid_down | ready_down))) begin
        n_fail++;
        $display("FAIL stream_model c=%0d: got %h want %h", c,
                 {ready_up, valid_down, last_down, grant_id, data_down}, m_vec());
      end
      if (valid_down && ready_down) begin
        n_tests++;
        if (sent.size() == 0 || data_down !== sent[0]) begin
          n_fail++;
          $display("FAIL stream_order: got %h want %h", data_down,
                   (sent.size() == 0) ? 32'hx : sent[0]);
        end
        if (sent.size() != 0) void'(sent.pop_front());
        rcvd++;
      end
      if (valid_up[0] && ready_up[0]) begin
        sent.push_back(32'hC000_0000 + beat);
        beat++;
      end
      tick();
    end
    n_tests++;
    if (rcvd != 5 || beat != 5) begin
      n_fail++;
      $display("FAIL stream_count: got sent=%0d rcvd=%0d want 5/5", beat, rcvd);
    end
    drain();
  endtask

  task automatic test_reset_midburst();
    valid_up = 4'b0100; last_up = 4'b0000; ready_down = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_data(2, 32'hF200_0000 + c);
      tick();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({valid_down, last_down, grant_id, data_down} !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b l=%b id=%0d d=%h want 0", valid_down, last_down, grant_id, data_down);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (valid_down !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_hold: got v=%b want 0", valid_down);
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid_up = 4'b0101; last_up = 4'b0101;
    set_data(0, 32'hF000_0009); set_data(2, 32'hF200_0009);
    #1;
    n_tests++;
    if (ready_up !== 4'b0001 || {ready_up, valid_down, last_down, grant_id, data_down} !== m_vec()) begin
      n_fail++;
      $display("FAIL midrst_prio: got rdy=%b want 0001", ready_up);
    end
    tick();
    valid_up = 4'b0100; last_up = 4'b0100;
    #1;
    n_tests++;
    if (ready_up !== 4'b0100 || {ready_up, valid_down, last_down, grant_id, data_down} !== m_vec()) begin
      n_fail++;
      $display("FAIL midrst_req2: got rdy=%b want 0100", ready_up);
    end
    tick();
    valid_up = '0;
    #1;
    n_tests++;
    if ({valid_down, grant_id, data_down} !== {1'b1, 2'd2, 32'hF200_0009}) begin
      n_fail++;
      $display("FAIL midrst_beat: got v=%b id=%0d d=%h want 1 2 f2000009", valid_down, grant_id, data_down);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      valid_up   = N'($urandom);
      last_up    = N'($urandom) & N'($urandom);
      ready_down = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      #1;
      n_tests++;
      if ({ready_up, valid_down, last_down, grant_id, data_down} !== m_vec() ||
          $countones(ready_up) > 1) begin
        n_fail++;
        $display("FAIL random c=%0d: got %h want %h", c,
                 {ready_up, valid_down, last_down, grant_id, data_down}, m_vec());
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_burst_lock();
    test_backpressure();
    test_wrap();
    test_stall_stream();
    test_reset_midburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
